// File: rtl/div_unit.sv
// Sequential signed restoring divider for the HI/LO write-back path.
// Quotient drives lo_out, remainder drives hi_out (MIPS DIV semantics).
module div_unit #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              start,
    output logic              stop,
    output logic              div_zero,
    output logic              busy,
    output logic [DATA_W-1:0] hi_out,
    output logic [DATA_W-1:0] lo_out
);

    localparam int CW = $clog2(DATA_W);

    typedef enum logic [1:0] {IDLE, RUN, FIX, ZERO} state_t;

    state_t            state;
    state_t            state_nx;
    logic [CW-1:0]     cnt;
    logic [DATA_W-1:0] rem;
    logic [DATA_W-1:0] dvd;
    logic [DATA_W-1:0] dsr;
    logic              sign_q;
    logic              sign_r;
    logic [DATA_W:0]   shifted;
    logic [DATA_W:0]   diff;
    logic              ge;
    logic              last;

    function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] v);
        return v[DATA_W-1] ? -v : v;
    endfunction

    // Guard bit keeps the compare/subtract exact for |b| up to 2^(DATA_W-1)
    assign shifted = {rem, dvd[DATA_W-1]};
    assign diff    = shifted - {1'b0, dsr};
    assign ge      = shifted >= {1'b0, dsr};
    assign last    = (cnt == CW'(DATA_W - 1));
    assign busy    = (state == RUN) || (state == FIX);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (start) state_nx = (b == '0) ? ZERO : RUN;
            RUN:  if (last) state_nx = FIX;
            FIX:  state_nx = IDLE;
            ZERO: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= '0;
            rem      <= '0;
            dvd      <= '0;
            dsr      <= '0;
            sign_q   <= 1'b0;
            sign_r   <= 1'b0;
            stop     <= 1'b0;
            div_zero <= 1'b0;
            hi_out   <= '0;
            lo_out   <= '0;
        end else begin
            stop     <= 1'b0;
            div_zero <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        if (b == '0) begin
                            div_zero <= 1'b1;
                        end else begin
                            dvd    <= mag(a);
                            dsr    <= mag(b);
                            sign_q <= a[DATA_W-1] ^ b[DATA_W-1];
                            sign_r <= a[DATA_W-1];
                            rem    <= '0;
                            cnt    <= '0;
                        end
                    end
                end
                RUN: begin
                    rem <= ge ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
                    dvd <= {dvd[DATA_W-2:0], ge};
                    cnt <= cnt + CW'(1);
                end
                FIX: begin
                    lo_out <= sign_q ? -dvd : dvd;
                    hi_out <= sign_r ? -rem : rem;
                    stop   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Directed + scoreboard bench for div_unit.
// Expected {hi,lo} pairs are queued at launch and popped on stop.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] a;
    logic [31:0] b;
    logic        start;
    logic        stop;
    logic        div_zero;
    logic        busy;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    int checks = 0;
    int failures = 0;
    logic [63:0] sb[$];

    always #5 clk = ~clk;

    div_unit #(.DATA_W(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .a        (a),
        .b        (b),
        .start    (start),
        .stop     (stop),
        .div_zero (div_zero),
        .busy     (busy),
        .hi_out   (hi_out),
        .lo_out   (lo_out)
    );

    function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] ux, uy, q, r;
        ux = x[31] ? -x : x;
        uy = y[31] ? -y : y;
        q = ux / uy;
        r = ux % uy;
        if (x[31] ^ y[31]) q = -q;
        if (x[31]) r = -r;
        return {r, q};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        a = x;
        b = y;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // n counts rising edges, the start-sampling edge being edge 1
    task automatic wait_done(input int n0, output int n, output logic hit);
        n = n0;
        hit = 1'b0;
        for (int i = 0; i < 60 && !hit; i++) begin
            @(negedge clk);
            if (stop || div_zero) hit = 1'b1;
            else begin
                @(posedge clk);
                n++;
            end
        end
    endtask

    task automatic pop_chk(input string tag);
        logic [63:0] e;
        chk({tag, "_sb"}, 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk(tag, {hi_out, lo_out}, e);
        end
    endtask

    task automatic run_div(input string tag, input logic [31:0] x,
                           input logic [31:0] y, input logic [63:0] exp);
        int n;
        logic hit;
        sb.push_back(exp);
        launch(x, y);
        chk({tag, "_busy"}, 64'(busy), 64'd1);
        wait_done(1, n, hit);
        chk({tag, "_done"}, 64'(hit), 64'd1);
        chk({tag, "_lat"}, 64'(n), 64'd34);
        chk({tag, "_flags"}, 64'({stop, div_zero}), 64'b10);
        pop_chk(tag);
        @(negedge clk);
        chk({tag, "_after"}, 64'({stop, busy}), 64'b00);
    endtask

    initial begin
        int n;
        logic hit;
        int seen;
        logic [31:0] rx, ry;

        reset = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset_flags", 64'({stop, div_zero, busy}), 64'd0);
        chk("reset_data", {hi_out, lo_out}, 64'd0);

        run_div("p7_2", 32'd7, 32'd2, {32'd1, 32'd3});
        run_div("m7_2", 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD});
        run_div("p7_m2", 32'd7, 32'hFFFFFFFE, {32'd1, 32'hFFFFFFFD});
        run_div("ovf", 32'h80000000, 32'hFFFFFFFF, {32'd0, 32'h80000000});
        run_div("p5_9", 32'd5, 32'd9, {32'd5, 32'd0});

        // Divide by zero keeps the previous result
        launch(32'd123, 32'd0);
        wait_done(1, n, hit);
        chk("dz_done", 64'(hit), 64'd1);
        chk("dz_lat", 64'(n), 64'd1);
        chk("dz_flags", 64'({stop, div_zero, busy}), 64'b010);
        chk("dz_hold", {hi_out, lo_out}, {32'd5, 32'd0});
        @(negedge clk);
        chk("dz_pulse", 64'({stop, div_zero}), 64'd0);

        // Restart attempt mid-run is ignored
        sb.push_back({32'd2, 32'd14});
        launch(32'd100, 32'd7);
        repeat (8) @(posedge clk);
        #1;
        a = 32'd55;
        b = 32'd3;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(10, n, hit);
        chk("rs_done", 64'(hit), 64'd1);
        chk("rs_lat", 64'(n), 64'd34);
        pop_chk("rs_res");

        // Reset in the middle of a division
        launch(32'd1000, 32'd3);
        repeat (13) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        chk("mr_flags", 64'({stop, div_zero, busy}), 64'd0);
        chk("mr_data", {hi_out, lo_out}, 64'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (stop || div_zero) seen++;
        end
        chk("mr_nostop", 64'(seen), 64'd0);
        run_div("p9_3", 32'd9, 32'd3, {32'd0, 32'd3});

        for (int i = 0; i < 4; i++) begin
            rx = $urandom;
            ry = $urandom;
            if (i == 1) ry = ry >> 20;
            if (ry == 0) ry = 32'd1;
            run_div("rand", rx, ry, model(rx, ry));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
